// File: rtl/mips_cpu_data_bus_if_pkg.sv
// Shared types and constants for the CPU data-side Avalon-MM bridge.
package mips_cpu_bus_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } bus_state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_cpu_data_bus_if_if.sv
// Avalon-MM data port bundle; the bridge is the master, memory the slave.
interface mips_cpu_data_bus_if_if;

    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        output avm_readdata, avm_waitrequest
    );

endinterface

// File: rtl/mips_cpu_data_bus_if_byte_lane_gen.sv
// Byte-lane enables, lane-replicated store data and alignment check for one access.
module byte_lane_gen
    import mips_cpu_bus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  byteenable,
    output logic [31:0] lane_data,
    output logic        misaligned
);

    always_comb begin
        byteenable = '0;
        lane_data  = '0;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                byteenable = 4'b0001 << addr_lo;
                lane_data  = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            SIZE_WORD: begin
                byteenable = BE_WORD;
                lane_data  = wdata;
                misaligned = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_cpu_data_bus_if.sv
// Data-side bridge: one Avalon-MM transaction per load/store, stalling the datapath until done.
module mips_cpu_data_bus_if
    import mips_cpu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_enable,
    input  logic                          mem_read,
    input  logic                          mem_write,
    input  logic [1:0]                    mem_size,
    input  logic [31:0]                   mem_addr,
    input  logic [31:0]                   mem_wdata,
    output logic                          stall,
    output logic [31:0]                   mem_rdata,
    output logic                          bus_error,
    mips_cpu_data_bus_if_if.master        avm
);

    localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

    logic [3:0]  lane_be;
    logic [31:0] lane_data;
    logic        misaligned;

    byte_lane_gen u_lanes (
        .size       (mem_size),
        .addr_lo    (mem_addr[1:0]),
        .wdata      (mem_wdata),
        .byteenable (lane_be),
        .lane_data  (lane_data),
        .misaligned (misaligned)
    );

    logic req_valid;
    logic req_invalid;
    logic timeout_hit;

    assign req_valid   = (mem_read ^ mem_write) && (mem_size != 2'b11) && !misaligned;
    assign req_invalid = (mem_read | mem_write) && !req_valid;

    bus_state_t  state, state_next;
    logic        issue, complete, abort;
    logic [31:0] wait_cnt;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic        read_q, write_q, bus_error_q;

    // Abort on the waitrequest cycle that brings the count up to the limit.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        issue      = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                stall = req_valid;
                if (clk_enable && req_valid) begin
                    issue      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (!avm.avm_waitrequest) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (clk_enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            bus_error_q <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (issue) begin
                addr_q   <= {mem_addr[31:2], 2'b00};
                be_q     <= lane_be;
                wdata_q  <= lane_data;
                read_q   <= mem_read;
                write_q  <= mem_write;
                wait_cnt <= '0;
            end
            if (state == IDLE && clk_enable && req_invalid) begin
                bus_error_q <= 1'b1;
                rdata_q     <= '0;
            end
            if (state == ACCESS && avm.avm_waitrequest) wait_cnt <= wait_cnt + 32'd1;
            if (complete) begin
                read_q  <= 1'b0;
                write_q <= 1'b0;
                if (read_q) rdata_q <= avm.avm_readdata;
            end
            if (abort) begin
                read_q      <= 1'b0;
                write_q     <= 1'b0;
                bus_error_q <= 1'b1;
                rdata_q     <= '0;
            end
        end
    end

    // A rejected request must never present stale load data to the selector.
    assign mem_rdata = (state == IDLE && req_invalid) ? 32'd0 : rdata_q;
    assign bus_error = bus_error_q;

    assign avm.avm_address    = addr_q;
    assign avm.avm_read       = read_q;
    assign avm.avm_write      = write_q;
    assign avm.avm_byteenable = be_q;
    assign avm.avm_writedata  = wdata_q;

endmodule

// File: tb/tb_mips_cpu_data_bus_if.sv
// Directed bench for the data-side bridge with a scripted Avalon slave.
module tb_mips_cpu_data_bus_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        mem_read, mem_write;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall;
    logic [31:0] mem_rdata;
    logic        bus_error;

    int n_cmp = 0;
    int n_bad = 0;

    mips_cpu_data_bus_if_if bus ();

    mips_cpu_data_bus_if #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_size   (mem_size),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .stall      (stall),
        .mem_rdata  (mem_rdata),
        .bus_error  (bus_error),
        .avm        (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
        mem_read  = rd;
        mem_write = wr;
        mem_size  = sz;
        mem_addr  = a;
        mem_wdata = d;
    endtask

    initial begin
        reset = 1'b0;
        clk_enable = 1'b1;
        req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'h0;
        #12;
        check_eq("rst_read",  {31'd0, bus.avm_read}, 32'd0);
        check_eq("rst_write", {31'd0, bus.avm_write}, 32'd0);
        check_eq("rst_addr",  bus.avm_address, 32'd0);
        check_eq("rst_be",    {28'd0, bus.avm_byteenable}, 32'd0);
        check_eq("rst_wd",    bus.avm_writedata, 32'd0);
        check_eq("rst_rdata", mem_rdata, 32'd0);
        check_eq("rst_err",   {31'd0, bus_error}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc();

        // Zero-wait word read
        req(1'b1, 1'b0, 2'b10, 32'h0000_1004, 32'h0);
        bus.avm_readdata = 32'hDEAD_BEEF;
        #1;
        check_eq("lw_c0_stall", {31'd0, stall}, 32'd1);
        cyc();
        check_eq("lw_c1_read",  {31'd0, bus.avm_read}, 32'd1);
        check_eq("lw_c1_addr",  bus.avm_address, 32'h0000_1004);
        check_eq("lw_c1_be",    {28'd0, bus.avm_byteenable}, 32'hF);
        check_eq("lw_c1_stall", {31'd0, stall}, 32'd1);
        cyc();
        check_eq("lw_c2_rdata", mem_rdata, 32'hDEAD_BEEF);
        check_eq("lw_c2_stall", {31'd0, stall}, 32'd0);
        check_eq("lw_c2_read",  {31'd0, bus.avm_read}, 32'd0);
        req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        cyc();

        // Byte store with four wait states
        req(1'b0, 1'b1, 2'b00, 32'h0000_2003, 32'h0000_00A5);
        bus.avm_waitrequest = 1'b1;
        #1;
        check_eq("sb_c0_stall", {31'd0, stall}, 32'd1);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            check_eq("sb_wr",    {31'd0, bus.avm_write}, 32'd1);
            check_eq("sb_addr",  bus.avm_address, 32'h0000_2000);
            check_eq("sb_be",    {28'd0, bus.avm_byteenable}, 32'h8);
            check_eq("sb_wd",    bus.avm_writedata, 32'hA5A5_A5A5);
            check_eq("sb_stall", {31'd0, stall}, 32'd1);
        end
        cyc();
        bus.avm_waitrequest = 1'b0;
        #1;
        check_eq("sb_c5_wr",    {31'd0, bus.avm_write}, 32'd1);
        check_eq("sb_c5_stall", {31'd0, stall}, 32'd1);
        cyc();
        check_eq("sb_c6_stall", {31'd0, stall}, 32'd0);
        check_eq("sb_c6_wr",    {31'd0, bus.avm_write}, 32'd0);
        check_eq("sb_c6_err",   {31'd0, bus_error}, 32'd0);
        req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        cyc();

        // Run-enable low in IDLE holds the request off the bus; low in ACCESS does not pause it
        clk_enable = 1'b0;
        req(1'b1, 1'b0, 2'b10, 32'h0000_0040, 32'h0);
        #1;
        check_eq("ce_idle_stall", {31'd0, stall}, 32'd1);
        cyc();
        check_eq("ce_idle_read1", {31'd0, bus.avm_read}, 32'd0);
        cyc();
        check_eq("ce_idle_read2", {31'd0, bus.avm_read}, 32'd0);
        check_eq("ce_idle_stall2", {31'd0, stall}, 32'd1);
        clk_enable = 1'b1;
        cyc();
        check_eq("ce_acc_read", {31'd0, bus.avm_read}, 32'd1);
        check_eq("ce_acc_addr", bus.avm_address, 32'h0000_0040);
        clk_enable = 1'b0;
        bus.avm_readdata = 32'h1234_5678;
        cyc();
        check_eq("ce_done_rdata", mem_rdata, 32'h1234_5678);
        check_eq("ce_done_stall", {31'd0, stall}, 32'd0);
        cyc();
        check_eq("ce_hold_stall", {31'd0, stall}, 32'd0);
        check_eq("ce_hold_read",  {31'd0, bus.avm_read}, 32'd0);
        check_eq("ce_hold_rdata", mem_rdata, 32'h1234_5678);
        req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        clk_enable = 1'b1;
        cyc();

        // Halfword store to the upper half
        req(1'b0, 1'b1, 2'b01, 32'h0000_3002, 32'h0000_BEEF);
        cyc();
        check_eq("sh_be",   {28'd0, bus.avm_byteenable}, 32'hC);
        check_eq("sh_wd",   bus.avm_writedata, 32'hBEEF_BEEF);
        check_eq("sh_addr", bus.avm_address, 32'h0000_3000);
        cyc();
        req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        cyc();

        // Timeout with waitrequest stuck high
        req(1'b1, 1'b0, 2'b10, 32'h0000_5000, 32'h0);
        bus.avm_waitrequest = 1'b1;
        bus.avm_readdata    = 32'hFFFF_FFFF;
        cyc();
        check_eq("to_c1_read", {31'd0, bus.avm_read}, 32'd1);
        for (int c = 2; c <= 8; c++) begin
            cyc();
            check_eq("to_read_held", {31'd0, bus.avm_read}, 32'd1);
        end
        check_eq("to_c8_err", {31'd0, bus_error}, 32'd0);
        cyc();
        check_eq("to_c9_read",  {31'd0, bus.avm_read}, 32'd0);
        check_eq("to_c9_err",   {31'd0, bus_error}, 32'd1);
        check_eq("to_c9_rdata", mem_rdata, 32'd0);
        check_eq("to_c9_stall", {31'd0, stall}, 32'd0);
        req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        cyc();

        // Reset mid-ACCESS
        req(1'b1, 1'b0, 2'b10, 32'h0000_6000, 32'h0);
        cyc();
        check_eq("rm_read_pre", {31'd0, bus.avm_read}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rm_read_async", {31'd0, bus.avm_read}, 32'd0);
        check_eq("rm_err_clr",    {31'd0, bus_error}, 32'd0);
        #2;
        reset = 1'b1;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'hCAFE_F00D;
        #1;
        check_eq("rm_idle_stall", {31'd0, stall}, 32'd1);
        cyc();
        check_eq("rm_acc_read", {31'd0, bus.avm_read}, 32'd1);
        cyc();
        check_eq("rm_rdata", mem_rdata, 32'hCAFE_F00D);
        req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        cyc();

        // Invalid requests: misaligned half, with run-enable low first
        clk_enable = 1'b0;
        req(1'b1, 1'b0, 2'b01, 32'h0000_3001, 32'h0);
        #1;
        check_eq("inv_stall",   {31'd0, stall}, 32'd0);
        check_eq("inv_rdata",   mem_rdata, 32'd0);
        cyc();
        check_eq("inv_ce0_err", {31'd0, bus_error}, 32'd0);
        clk_enable = 1'b1;
        cyc();
        check_eq("inv_read", {31'd0, bus.avm_read}, 32'd0);
        check_eq("inv_err",  {31'd0, bus_error}, 32'd1);
        req(1'b1, 1'b1, 2'b10, 32'h0000_3000, 32'h0);
        #1;
        check_eq("both_stall", {31'd0, stall}, 32'd0);
        cyc();
        check_eq("both_read",  {31'd0, bus.avm_read}, 32'd0);
        check_eq("both_write", {31'd0, bus.avm_write}, 32'd0);
        req(1'b1, 1'b0, 2'b11, 32'h0000_3000, 32'h0);
        #1;
        check_eq("sz3_stall", {31'd0, stall}, 32'd0);
        cyc();
        check_eq("sz3_read", {31'd0, bus.avm_read}, 32'd0);
        req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        cyc();
        cyc();
        check_eq("err_sticky", {31'd0, bus_error}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_cpu_data_bus_if.md
# mips_cpu_data_bus_if

Data-side memory bridge between the Harvard CPU datapath and an Avalon-MM data memory port. It takes the datapath's data address, write data and a load/store request, performs one bus transaction with a waitrequest handshake and per-byte enables, and stalls the datapath until the transaction completes. It sits directly downstream of the datapath's `data_address`/`data_writedata` outputs and directly upstream of its `data_readdata` input. SB/SH become single masked writes, with no read-modify-write.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles `avm_waitrequest` may stay high before abort; 0 disables the timeout.
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low.
- `clk_enable` in 1: CPU run enable.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request.
- `mem_size` in 2: 00 byte, 01 half, 10 word; 11 is illegal.
- `mem_addr` in 32: byte address from the ALU.
- `mem_wdata` in 32: store data. A byte/half is presented in bits [7:0]/[15:0].
- `stall` out 1: hold PC and pipeline.
- `mem_rdata` out 32: full aligned word for the load selector.
- `bus_error` out 1: sticky error flag.
- `avm_address` out 32: word-aligned address.
- `avm_read`, `avm_write` out 1: bus strobes.
- `avm_byteenable` out 4: byte-lane enables.
- `avm_writedata` out 32: lane-shifted store data.
- `avm_readdata` in 32: read data from memory.
- `avm_waitrequest` in 1: slave not ready.

## Operation
- States: IDLE, ACCESS, DONE.
- **Request:** a valid request is (`mem_read` XOR `mem_write`), with a legal size and natural alignment (half: addr[0]=0; word: addr[1:0]=0).
- **IDLE:**
  - `stall` is asserted combinationally whenever a valid request is present, independent of `clk_enable`.
  - If `clk_enable`=1 and the request is valid, the bridge registers all `avm_*` outputs and moves to ACCESS.
  - Registered `avm_*` values: `avm_address`={addr[31:2],2'b00}.
  - Byteenable: byte → 1<<addr[1:0]; half → 0011 or 1100; word → 1111.
  - Writedata: replicated lanes (byte x4, half x2).
- **Invalid request:** both strobes high, misaligned address, or size 11.
  - No bus cycle is issued and `stall` stays 0.
  - `bus_error` is set on the clock edge only when `clk_enable`=1.
  - `mem_rdata` is 0.
- **ACCESS:**
  - `avm_read`/`avm_write` are held high, with address, byteenable and writedata stable, until a cycle in which `avm_waitrequest`=0.
  - On that edge, reads latch `avm_readdata` into `mem_rdata`; strobes drop and the FSM moves to DONE.
  - `clk_enable`=0 does not pause ACCESS; the Avalon handshake is never abandoned.
- **Timeout:**
  - The wait counter increments every ACCESS cycle with waitrequest=1.
  - When the count reaches `TIMEOUT_CYCLES`: strobes drop, `bus_error` is set, `mem_rdata`=0, and the FSM moves to DONE.
- **DONE:**
  - `stall`=0 and `mem_rdata` is valid.
  - If `clk_enable`=1 the FSM returns to IDLE; otherwise it holds DONE.
  - The request still present in DONE is not reissued.
- **Persistence:** `bus_error` clears only on reset.

## Timing
- Reset values: state IDLE, `avm_read`=`avm_write`=0, `avm_address`=0, `avm_byteenable`=0, `avm_writedata`=0, `mem_rdata`=0, `bus_error`=0, counter 0, `stall`=0 (with no request).
- Reset asserted mid-ACCESS drops the strobes immediately (asynchronously).
- Zero-wait read:
  - Cycle 0: IDLE, `stall`=1.
  - Cycle 1: ACCESS, `avm_read`=1.
  - Cycle 2: DONE, `mem_rdata` valid, `stall`=0; the datapath advances at the end of cycle 2.
- Minimum access latency is 3 cycles. Each waitrequest cycle adds 1.
- Worst case before abort: 2 + `TIMEOUT_CYCLES` cycles.
- At most one outstanding transaction; no pipelining.

## Structure
- Package `mips_cpu_bus_pkg`:
  - `size_t` enum: SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - `bus_state_t` enum: IDLE, ACCESS, DONE.
  - Constant BE_WORD=4'b1111.
- Sub-module `byte_lane_gen` (combinational):
  - In: size, addr[1:0], wdata.
  - Out: byteenable, lane data, misaligned flag.
- The top level holds the FSM, the timeout counter and the output registers.

## Test plan
- **Zero-wait word read:** `mem_read`=1, size 10, addr 0x1004, readdata 0xDEADBEEF, waitrequest=0 → `avm_address` 0x1004, BE 1111, `stall` high for cycles 0-1, `mem_rdata` 0xDEADBEEF in cycle 2.
- **Wait-stated SB:** `mem_write`=1, size 00, addr 0x2003, wdata 0x000000A5, waitrequest high for 4 cycles → strobes and data stable throughout, BE 1000, writedata 0xA5A5A5A5, `stall` released 6 cycles after request.
- **Misaligned/illegal request:** half at 0x3001, or both strobes high → no `avm_read`/`avm_write`, `stall`=0, `bus_error`=1 and sticky.
- **Timeout:** `TIMEOUT_CYCLES`=8, waitrequest stuck high → strobe drops after 8 ACCESS cycles, `bus_error`=1, `mem_rdata`=0, `stall` releases the following cycle.
- **Reset mid-ACCESS:** `reset` low during ACCESS → `avm_read` low asynchronously; after release, the FSM is in IDLE and a new read completes normally.
- **Run-enable low:** `clk_enable`=0 during ACCESS → transaction completes and the FSM holds DONE; `clk_enable`=0 in IDLE with a valid request → no bus cycle issued while `stall`=1.
